// File: rtl/calc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : calc_mem_pkg
// Description : Shared constants, command encodings and state encoding for the
//               calculator stack engine and its Memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_mem_pkg;

    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;

    // Command encodings carried on cmd_op
    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_PEEK  = 2'b10,
        OP_CLEAR = 2'b11
    } op_e;

    // Engine states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD   = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

endpackage : calc_mem_pkg
`default_nettype wire

// File: rtl/calc_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : calc_stack_ctrl
// Description : LIFO stack engine driving a single synchronous Memory. Accepts
//               push/pop/peek/clear commands in IDLE, sequences the memory
//               access and returns a one-cycle response strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_stack_ctrl
    import calc_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_op,
    input  logic [DATA_W-1:0]            cmd_data,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_err,
    output logic [$clog2(DEPTH+1)-1:0]   depth,
    output logic                         full,
    output logic                         empty,
    output logic [ADDR_W-1:0]            mem_address,
    output logic [DATA_W-1:0]            mem_data,
    output logic                         mem_we,
    input  logic [DATA_W-1:0]            mem_data_out
);

    localparam int unsigned SP_W  = $clog2(DEPTH + 1);
    localparam int unsigned CNT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    state_e              state_q,       state_d;
    op_e                 op_q,          op_d;
    logic [SP_W-1:0]     sp_q,          sp_d;
    logic [CNT_W-1:0]    rd_cnt_q,      rd_cnt_d;
    logic                rsp_valid_q,   rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q,    rsp_data_d;
    logic                rsp_err_q,     rsp_err_d;
    logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
    logic [DATA_W-1:0]   mem_data_q,    mem_data_d;
    logic                mem_we_q,      mem_we_d;
    logic                full_q,        full_d;
    logic                empty_q,       empty_d;

    // Address of the next free slot and of the current top-of-stack entry
    logic [ADDR_W-1:0]   w_push_addr;
    logic [ADDR_W-1:0]   w_top_addr;
    logic                w_is_full;
    logic                w_is_empty;

    assign w_push_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(sp_q);
    assign w_top_addr  = ADDR_W'(BASE_ADDR) + ADDR_W'(sp_q - SP_W'(1));
    assign w_is_full   = (sp_q == SP_W'(DEPTH));
    assign w_is_empty  = (sp_q == '0);

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_err     = rsp_err_q;
    assign depth       = sp_q;
    assign full        = full_q;
    assign empty       = empty_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign mem_we      = mem_we_q;

    // Next-state, stack pointer and Memory/response outputs; responses are
    // launched on the edge entering RSP so rsp_valid is high only in RSP
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        sp_d          = sp_q;
        rd_cnt_d      = rd_cnt_q;
        rsp_valid_d   = 1'b0;
        rsp_data_d    = rsp_data_q;
        rsp_err_d     = rsp_err_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_we_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d = op_e'(cmd_op);
                    unique case (op_e'(cmd_op))
                        OP_PUSH: begin
                            if (w_is_full) begin
                                state_d     = ST_RSP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                                rsp_data_d  = '0;
                            end else begin
                                state_d       = ST_WR;
                                mem_we_d      = 1'b1;
                                mem_address_d = w_push_addr;
                                mem_data_d    = cmd_data;
                            end
                        end
                        OP_POP, OP_PEEK: begin
                            if (w_is_empty) begin
                                state_d     = ST_RSP;
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                                rsp_data_d  = '0;
                            end else begin
                                state_d       = ST_RD;
                                mem_address_d = w_top_addr;
                                rd_cnt_d      = '0;
                            end
                        end
                        OP_CLEAR: begin
                            state_d     = ST_RSP;
                            sp_d        = '0;
                            rsp_valid_d = 1'b1;
                            rsp_err_d   = 1'b0;
                            rsp_data_d  = '0;
                        end
                    endcase
                end
            end
            ST_WR: begin
                // Write commits on this edge; the entry becomes visible
                state_d     = ST_RSP;
                sp_d        = sp_q + SP_W'(1);
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = '0;
            end
            ST_RD: begin
                // Address is held RD_LAT+1 cycles; capture on the last edge
                if (rd_cnt_q == CNT_W'(RD_LAT)) begin
                    state_d     = ST_RSP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = mem_data_out;
                    if (op_q == OP_POP) begin
                        sp_d = sp_q - SP_W'(1);
                    end
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
            ST_RSP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        full_d  = (sp_d == SP_W'(DEPTH));
        empty_d = (sp_d == '0);
    end

    // State and datapath registers; reset aborts any operation and drops mem_we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_PUSH;
            sp_q          <= '0;
            rd_cnt_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_we_q      <= 1'b0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            sp_q          <= sp_d;
            rd_cnt_q      <= rd_cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_err_q     <= rsp_err_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_we_q      <= mem_we_d;
            full_q        <= full_d;
            empty_q       <= empty_d;
        end
    end

endmodule : calc_stack_ctrl
`default_nettype wire

// File: tb/tb_calc_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_stack_ctrl
// Description : Directed, table-driven bench for calc_stack_ctrl (DEPTH=4)
//               with a behavioural synchronous Memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_stack_ctrl;
    import calc_mem_pkg::*;

    localparam int unsigned DEPTH_P = 4;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  depth;
    logic        full;
    logic        empty;
    logic [7:0]  mem_address;
    logic [31:0] mem_data;
    logic        mem_we;
    logic [31:0] mem_data_out;

    logic [31:0] mem [0:255];

    int n_tests = 0;
    int n_fail  = 0;
    time prev_acc = 0;
    time last_acc = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] data;
        logic        err;
        logic [31:0] rdata;
        int          depth;
        int          we_cnt;
        logic [7:0]  waddr;
        int          lat;
        bit          chk_gap;
    } vec_t;

    vec_t vecs [13];

    calc_stack_ctrl #(
        .ADDR_W    (8),
        .DATA_W    (32),
        .DEPTH     (DEPTH_P),
        .BASE_ADDR (0),
        .RD_LAT    (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .depth        (depth),
        .full         (full),
        .empty        (empty),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous Memory with one clock of read latency
    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_data;
        mem_data_out <= mem[mem_address];
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one command from a negedge and follow it to its response
    task automatic run_vec(input vec_t v, input int idx);
        int          n;
        int          we_n;
        int          lat;
        bit          got;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic [7:0]  addr0;
        logic        exp_full;
        logic        exp_empty;
        addr0     = mem_address;
        wa        = '0;
        wd        = '0;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_data  = v.data;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check($sformatf("v%0d_accept_timeout", idx), 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        prev_acc = last_acc;
        last_acc = $time;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = 32'hDEAD_BEEF;
        we_n = 0;
        lat  = 0;
        got  = 1'b0;
        while (!got && lat < 20) begin
            lat++;
            if (mem_we) begin
                we_n++;
                wa = mem_address;
                wd = mem_data;
            end
            if (rsp_valid) got = 1'b1;
            else @(negedge clk);
        end
        exp_full  = (v.depth == DEPTH_P);
        exp_empty = (v.depth == 0);
        check($sformatf("v%0d_rsp_seen", idx), 32'(got), 32'd1);
        check($sformatf("v%0d_latency", idx), lat, v.lat);
        check($sformatf("v%0d_rsp_err", idx), 32'(rsp_err), 32'(v.err));
        check($sformatf("v%0d_rsp_data", idx), rsp_data, v.rdata);
        check($sformatf("v%0d_depth", idx), 32'(depth), v.depth);
        check($sformatf("v%0d_full", idx), 32'(full), 32'(exp_full));
        check($sformatf("v%0d_empty", idx), 32'(empty), 32'(exp_empty));
        check($sformatf("v%0d_we_count", idx), we_n, v.we_cnt);
        if (v.we_cnt > 0) begin
            check($sformatf("v%0d_wr_addr", idx), 32'(wa), 32'(v.waddr));
            check($sformatf("v%0d_wr_data", idx), wd, v.data);
        end
        if (v.lat == 1) begin
            check($sformatf("v%0d_addr_held", idx), 32'(mem_address), 32'(addr0));
        end
        if (v.chk_gap) begin
            check($sformatf("v%0d_push_gap", idx), 32'((last_acc - prev_acc) / 10), 32'd3);
        end
        @(negedge clk);
        check($sformatf("v%0d_rsp_one_cycle", idx), 32'(rsp_valid), 32'd0);
        check($sformatf("v%0d_rsp_data_hold", idx), rsp_data, v.rdata);
    endtask

    initial begin
        vec_t v;
        // op, data, err, rdata, depth, we_cnt, waddr, lat, chk_gap
        vecs[0]  = '{OP_PUSH,  32'd1,    1'b0, 32'd0,    1, 1, 8'd0, 2, 1'b0};
        vecs[1]  = '{OP_PUSH,  32'd10,   1'b0, 32'd0,    2, 1, 8'd1, 2, 1'b1};
        vecs[2]  = '{OP_PUSH,  32'd100,  1'b0, 32'd0,    3, 1, 8'd2, 2, 1'b1};
        vecs[3]  = '{OP_PUSH,  32'd1000, 1'b0, 32'd0,    4, 1, 8'd3, 2, 1'b1};
        vecs[4]  = '{OP_PUSH,  32'd511,  1'b1, 32'd0,    4, 0, 8'd0, 1, 1'b0};
        vecs[5]  = '{OP_POP,   32'd0,    1'b0, 32'd1000, 3, 0, 8'd0, 3, 1'b0};
        vecs[6]  = '{OP_POP,   32'd0,    1'b0, 32'd100,  2, 0, 8'd0, 3, 1'b0};
        vecs[7]  = '{OP_PEEK,  32'd0,    1'b0, 32'd10,   2, 0, 8'd0, 3, 1'b0};
        vecs[8]  = '{OP_PUSH,  32'd102,  1'b0, 32'd0,    3, 1, 8'd2, 2, 1'b0};
        vecs[9]  = '{OP_PEEK,  32'd0,    1'b0, 32'd102,  3, 0, 8'd0, 3, 1'b0};
        vecs[10] = '{OP_CLEAR, 32'd0,    1'b0, 32'd0,    0, 0, 8'd0, 1, 1'b0};
        vecs[11] = '{OP_POP,   32'd0,    1'b1, 32'd0,    0, 0, 8'd0, 1, 1'b0};
        vecs[12] = '{OP_PEEK,  32'd0,    1'b1, 32'd0,    0, 0, 8'd0, 1, 1'b0};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset asserted during the WR cycle of a push
        v = '{OP_PUSH, 32'd55, 1'b0, 32'd0, 1, 1, 8'd0, 2, 1'b0};
        run_vec(v, 13);
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_data  = 32'd66;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst_wr_active", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_depth", 32'(depth), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        repeat (2) @(negedge clk);
        check("midrst_rsp_valid_hold", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{OP_PUSH, 32'd77, 1'b0, 32'd0, 1, 1, 8'd0, 2, 1'b0};
        run_vec(v, 14);
        v = '{OP_POP, 32'd0, 1'b0, 32'd77, 0, 0, 8'd0, 3, 1'b0};
        run_vec(v, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_calc_stack_ctrl
`default_nettype wire

// File: doc/calc_stack_ctrl.md
Name: calc_stack_ctrl

Overview:
LIFO stack engine that acts as the initiator on the Memory port (address/data/we in, data_out back). CalcuTEC control issues push/pop/peek/clear commands over a valid/ready handshake. The block owns the stack pointer, sequences the Memory writes and synchronous reads, and returns results or errors on a one-cycle response strobe. It sits between the calculator control FSM and the single Memory instance.

Parameters:
ADDR_W, 8, Memory address width.
DATA_W, 32, stack word width; equals Memory data width.
DEPTH, 256, maximum entries; must satisfy BASE_ADDR+DEPTH <= 2**ADDR_W.
BASE_ADDR, 0, Memory address of stack entry 0.
RD_LAT, 1, Memory read latency in clocks (address edge to data_out valid).

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  00 push, 01 pop, 10 peek, 11 clear
cmd_data  in  DATA_W  push operand, sampled only on accept
rsp_valid  out  1  one-cycle completion strobe
rsp_data  out  DATA_W  pop/peek result; 0 for push/clear/error
rsp_err  out  1  qualified by rsp_valid; overflow/underflow
depth  out  clog2(DEPTH+1)  current entry count (sp)
full  out  1  sp == DEPTH
empty  out  1  sp == 0
mem_address  out  ADDR_W  to Memory address
mem_data  out  DATA_W  to Memory data
mem_we  out  1  to Memory we
mem_data_out  in  DATA_W  from Memory data_out

Behaviour:
- Reset (async, rst_n low): state IDLE, sp=0, rsp_valid=0, rsp_err=0, rsp_data=0, mem_we=0, mem_address=0, mem_data=0. cmd_ready follows state, so it is 1, but no command is accepted while rst_n is low. Memory contents are not cleared.
- Accept: cmd_valid && cmd_ready at rising edge E0. cmd_op and cmd_data are latched. cmd_valid is ignored in other states; there is no queuing.
- States: IDLE, WR, RD, RSP.
- Push, not full: IDLE->WR. During WR, mem_address=BASE_ADDR+sp, mem_data=operand, mem_we=1 for exactly one cycle. At E1 the write commits and sp increments. WR->RSP, rsp_valid=1 during E1..E2, then IDLE. Throughput is 1 push per 3 clocks.
- Pop/peek, not empty: IDLE->RD. mem_address=BASE_ADDR+sp-1 and mem_we=0, held for RD_LAT+1 cycles. On the final RD edge, rsp_data<=mem_data_out. Pop decrements sp on that same edge; peek leaves sp unchanged. RD->RSP, then IDLE. With RD_LAT=1, rsp_valid is high during E2..E3.
- Push when full: IDLE->RSP directly. No memory access, sp unchanged, rsp_err=1, rsp_data=0.
- Pop/peek when empty: IDLE->RSP directly. No memory access, sp unchanged, rsp_err=1, rsp_data=0.
- Clear: IDLE->RSP. sp<=0, no memory access, rsp_err=0.
- rsp_valid is a single cycle with no backpressure. rsp_data and rsp_err hold until the next RSP.
- Outside WR, mem_we=0. mem_address and mem_data hold their last values.
- Reset mid-operation: the operation is aborted and mem_we drops asynchronously. A write in flight is not guaranteed to commit.
- full, empty and depth are registered from sp and update on the edge where sp changes.
- Address arithmetic is ADDR_W bits. The parameter constraint guarantees no wrap past 2**ADDR_W-1.

Decomposition:
- Package calc_mem_pkg: ADDR_W and DATA_W defaults, cmd_op encodings (OP_PUSH, OP_POP, OP_PEEK, OP_CLEAR), state enum (ST_IDLE, ST_WR, ST_RD, ST_RSP).
- Single module. The RD_LAT wait counter and sp live inline; no sub-module is warranted.

Test Plan:
- Reset, then push 1, 10, 100, 1000 -> mem_we pulses at addresses 0..3 with those data values; depth=4; each rsp_valid has rsp_err=0; push spacing is 3 clocks.
- From depth 4: pop, pop -> rsp_data=1000 then 100; depth=2; mem_we stays 0 throughout.
- Peek at depth 2 -> rsp_data=10, depth remains 2. Then push 102 -> write to address 2. Then peek -> rsp_data=102.
- Clear, then pop -> rsp_err=1, rsp_data=0, no address change, depth=0, empty=1.
- DEPTH=4: push 4 values then push 511 -> rsp_err=1, full=1, no mem_we, depth=4. Then pop -> rsp_data equals the 4th value pushed.
- Assert rst_n low during the WR cycle of a push -> mem_we drops immediately; depth=0, rsp_valid=0. After release, a push succeeds at address 0.
